alu_control_seq: RTL and testbench

//  Successor ALU-control unit: decodes aluop/funct into the ALU selector and sequences multi-cycle ops.

---
 rtl/alu_control_seq.sv | 132 +++++++++++++
 tb/tb_alu_control_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU control sequencer: decodes aluop/funct into a registered ALU selector,
// holds MUL/DIV selectors for a fixed number of stall cycles, and hands the
// selector to the ALU under a valid/ready handshake.
module alu_control_seq #(
  parameter int FUNC_W  = 6,
  parameter int OPS_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [FUNC_W-1:0] funct,
  output logic [OPS_W-1:0]  ops,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] F_NOR = FUNC_W'(6'b100111);
  localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(6'b000010);
  localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] F_DIV = FUNC_W'(6'b011010);
  localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'b101010);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, VALID} state_t;

  state_t             state_q, state_d;
  logic [OPS_W-1:0]   ops_q, ops_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         dec_ops;
  logic               dec_illegal;
  logic               dec_mul;
  logic               dec_div;
  logic               accept;

  // Decode the incoming aluop/funct into selector, illegal flag and op class
  always_comb begin
    dec_ops     = 4'b1111;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    case (aluop)
      2'b00: dec_ops = 4'b0010;
      2'b01: dec_ops = 4'b0110;
      2'b11: dec_ops = 4'b1011;
      default: begin
        case (funct)
          F_AND: dec_ops = 4'b0000;
          F_OR:  dec_ops = 4'b0001;
          F_ADD: dec_ops = 4'b0010;
          F_NOR: dec_ops = 4'b0100;
          F_MUL: begin dec_ops = 4'b0101; dec_mul = 1'b1; end
          F_SUB: dec_ops = 4'b0110;
          F_DIV: begin dec_ops = 4'b1000; dec_div = 1'b1; end
          F_SLT: dec_ops = 4'b1001;
          default: begin dec_ops = 4'b1111; dec_illegal = 1'b1; end
        endcase
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == VALID) & out_ready);
  assign accept    = in_valid & in_ready;
  assign ops       = ops_q;
  assign illegal   = illegal_q;
  assign out_valid = (state_q == VALID);
  assign busy      = (state_q == BUSY);

  // Next-state: load on accept, count down stall cycles, release on out_ready
  always_comb begin
    state_d   = state_q;
    ops_d     = ops_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      BUSY: begin
        if (cnt_q == '0) state_d = VALID;
        else             cnt_d   = cnt_q - 1'b1;
      end
      VALID: begin
        // Without a new op, drain to IDLE once the consumer takes the result
        if (out_ready && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept only happens from IDLE or a draining VALID, so it overrides both
    if (accept) begin
      ops_d     = OPS_W'(dec_ops);
      illegal_d = dec_illegal;
      cnt_d     = '0;
      state_d   = VALID;
      if (dec_mul && MUL_LAT > 1) begin
        state_d = BUSY;
        cnt_d   = MUL_CNT;
      end else if (dec_div && DIV_LAT > 1) begin
        state_d = BUSY;
        cnt_d   = DIV_CNT;
      end
    end
  end

  // State and output registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ops_q     <= OPS_W'(4'b1111);
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ops_q     <= ops_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_control_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] aluop = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] ops;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  alu_control_seq #(.FUNC_W(6), .OPS_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .ops(ops), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: selector, illegal flag and hold latency of an op
  task automatic ref_dec(input logic [1:0] a, input logic [5:0] f,
                         output logic [3:0] o, output logic il, output int lat);
    il = 1'b0; lat = 1;
    case (a)
      2'b00: o = 4'h2;
      2'b01: o = 4'h6;
      2'b11: o = 4'hB;
      default:
        case (f)
          6'h24: o = 4'h0;
          6'h25: o = 4'h1;
          6'h20: o = 4'h2;
          6'h27: o = 4'h4;
          6'h02: begin o = 4'h5; lat = MUL_LAT; end
          6'h22: o = 4'h6;
          6'h1A: begin o = 4'h8; lat = DIV_LAT; end
          6'h2A: o = 4'h9;
          default: begin o = 4'hF; il = 1'b1; end
        endcase
    endcase
  endtask

  // Model: result-held flag plus remaining stall cycles
  logic       m_valid = 1'b0;
  int         m_busy  = 0;
  logic [3:0] m_ops   = 4'hF;
  logic       m_ill   = 1'b0;
  logic       exp_in_ready;

  assign exp_in_ready = (!m_valid && m_busy == 0) || (m_valid && out_ready);

  always @(posedge clk or posedge rst) begin : mdl
    int b, lat;
    logic v, il;
    logic [3:0] o;
    if (rst) begin
      m_valid <= 1'b0; m_busy <= 0; m_ops <= 4'hF; m_ill <= 1'b0;
    end else begin
      b = m_busy; v = m_valid; o = m_ops; il = m_ill; lat = 1;
      if (b > 0) begin
        b = b - 1;
        if (b == 0) v = 1'b1;
      end else if (v && out_ready) begin
        v = 1'b0;
      end
      if (in_valid && exp_in_ready) begin
        ref_dec(aluop, funct, o, il, lat);
        if (lat <= 1) v = 1'b1;
        else begin v = 1'b0; b = lat; end
      end
      m_busy <= b; m_valid <= v; m_ops <= o; m_ill <= il;
    end
  end

  // Compare process: outputs sampled mid-cycle against the model
  always @(negedge clk) begin
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_busy", 32'(busy), 32'(m_busy > 0));
    chk("m_in_ready", 32'(in_ready), 32'(exp_in_ready));
    chk("m_ops", 32'(ops), 32'(m_ops));
    if (m_valid) chk("m_illegal", 32'(illegal), 32'(m_ill));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fl [8] = '{6'h24, 6'h25, 6'h20, 6'h27, 6'h22, 6'h2A, 6'h02, 6'h1A};
  logic [3:0] fe [6] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h9};
  logic [1:0] ba [3] = '{2'b00, 2'b01, 2'b11};
  logic [3:0] be [3] = '{4'h2, 4'h6, 4'hB};

  initial begin
    int n, bc;
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_ops", 32'(ops), 32'hF);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_illegal", 32'(illegal), 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Non-R-type back-to-back
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; aluop = ba[i];
      step();
      chk("b2b_ops", 32'(ops), 32'(be[i]));
      chk("b2b_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(out_valid), 0);

    // R-type single-cycle functs, then an illegal one
    aluop = 2'b10;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; funct = fl[i];
      step();
      chk("rtype_ops", 32'(ops), 32'(fe[i]));
      chk("rtype_ill", 32'(illegal), 0);
    end
    funct = 6'h3F;
    step();
    chk("illegal_ops", 32'(ops), 32'hF);
    chk("illegal_flag", 32'(illegal), 1);
    chk("illegal_nobusy", 32'(busy), 0);
    in_valid = 1'b0;
    step();

    // MUL: stall length and accept-to-valid distance
    in_valid = 1'b1; funct = 6'h02;
    step();
    in_valid = 1'b0;
    n = 0; bc = 0;
    while (!out_valid && n < 20) begin
      if (busy) bc++;
      chk("mul_ops_held", 32'(ops), 32'h5);
      step(); n++;
    end
    chk("mul_busy_cycles", bc, 4);
    chk("mul_latency", n, 4);
    chk("mul_ops", 32'(ops), 32'h5);
    step();

    // DIV followed by a queued ADD with in_valid held
    in_valid = 1'b1; aluop = 2'b10; funct = 6'h1A;
    step();
    aluop = 2'b00;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("div_in_ready", 32'(in_ready), 0);
      step(); n++;
    end
    chk("div_latency", n, 8);
    chk("div_ops", 32'(ops), 32'h8);
    step();
    chk("queued_add_ops", 32'(ops), 32'h2);
    chk("queued_add_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    step();

    // Backpressure for 3 cycles in VALID
    in_valid = 1'b1; aluop = 2'b01;
    step();
    out_ready = 1'b0; aluop = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ops", 32'(ops), 32'h6);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ops", 32'(ops), 32'h2);
    in_valid = 1'b0;
    step(); step();

    // Reset while DIV is stalled with cnt=3
    in_valid = 1'b1; aluop = 2'b10; funct = 6'h1A;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_ops", 32'(ops), 32'hF);
    chk("abort_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      aluop     = 2'($urandom);
      funct     = ($urandom % 5 == 0) ? 6'($urandom) : fl[$urandom % 8];
      rst       = ($urandom % 250) == 0;
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
